mole_scheduler: RTL and testbench

- Parametrised successor to the fixed three-mole generator.
- Maintains NUM_MOLES independent mole slots. Each slot holds a distinct hole, its own lifetime countdown and hit/expiry tracking.
- Fills free slots with LFSR-drawn, collision-free holes on each spawn request, and reports hits, misses and wrong whacks to the score/display logic.
- Sits between the game-timing divider (spawn_tick, age_tick) and the display/score path.

---
 rtl/mole_pkg.sv | 31 +++
 rtl/mole_scheduler_lfsr.sv | 22 ++
 rtl/mole_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_mole_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the mole scheduler.
// FSM states, slot record, LFSR mask and width helper.
package mole_pkg;

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam int MAX_HOLES = 64;
   localparam int LIFE_MAX_W = 16;

   // Bits needed to index n holes (at least 1).
   function automatic int hole_w(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < n) w = i + 1;
      return w;
   endfunction

   localparam int POS_W = hole_w(MAX_HOLES);

   typedef enum logic {
      IDLE  = 1'b0,
      SPAWN = 1'b1
   } state_t;

   typedef struct packed {
      logic                  active;
      logic [POS_W-1:0]      pos;
      logic [LIFE_MAX_W-1:0] life;
   } slot_t;

endpackage

// File: rtl/mole_scheduler_lfsr.sv
// Galois LFSR with enable; right-shifting form.
// Feedback mask is XORed in whenever the output bit is 1.
module lfsr_galois #(
   parameter int           W    = 16,
   parameter logic [W-1:0] MASK = '0,
   parameter logic [W-1:0] SEED = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] state
);

   // Shift once per enabled clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= SEED;
      else if (en)
         state <= state[0] ? ((state >> 1) ^ MASK) : (state >> 1);
   end

endmodule

// File: rtl/mole_scheduler.sv
// Multi-slot mole scheduler: LFSR spawning, aging, whacks.
// Reports hits, misses and wrong whacks with saturating totals.
module mole_scheduler
   import mole_pkg::*;
#(
   parameter int          NUM_MOLES = 3,
   parameter int          NUM_HOLES = 18,
   parameter int          LIFE_W    = 4,
   parameter int          MAX_TRIES = 8,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 spawn_tick,
   input  logic                 age_tick,
   input  logic [LIFE_W-1:0]    lifetime,
   input  logic [NUM_HOLES-1:0] whack,
   input  logic                 clear_scores,
   output logic [NUM_HOLES-1:0] mole_positions,
   output logic                 busy,
   output logic                 hit_pulse,
   output logic                 miss_pulse,
   output logic                 wrong_pulse,
   output logic [CNT_W-1:0]     hit_count,
   output logic [CNT_W-1:0]     miss_count
);

   localparam logic [15:0] SEED_EFF =
      (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam int KW = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam int CMAX = (1 << CNT_W) - 1;

   slot_t                  slots_q [NUM_MOLES];
   slot_t                  slots_d [NUM_MOLES];
   state_t                 state_q, state_d;
   logic [KW-1:0]          k_q, k_d;
   logic [TW-1:0]          tries_q, tries_d;
   logic [15:0]            lfsr;
   logic [MAX_HOLES-1:0]   occ;
   logic [MAX_HOLES-1:0]   whack_ext;
   logic [POS_W-1:0]       cand;
   logic                   cand_ok;
   logic [LIFE_MAX_W-1:0]  life_ld;
   logic [NUM_MOLES-1:0]   hit_v;
   logic [NUM_MOLES-1:0]   miss_v;
   logic                   wrong;
   logic                   adv;
   logic                   unused_lfsr;

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] c,
      input int               n
   );
      int s;
      s = int'(c) + n;
      return (s > CMAX) ? CNT_W'(CMAX) : CNT_W'(s);
   endfunction

   lfsr_galois #(
      .W    (16),
      .MASK (LFSR_MASK),
      .SEED (SEED_EFF)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (enable),
      .state (lfsr)
   );

   assign unused_lfsr = ^lfsr[15:POS_W];
   assign cand        = lfsr[POS_W-1:0];
   assign whack_ext   = MAX_HOLES'(whack);
   assign cand_ok     = (int'(cand) < NUM_HOLES) && !occ[cand];
   assign life_ld     = (lifetime == '0) ? LIFE_MAX_W'(1)
                                         : LIFE_MAX_W'(lifetime);
   assign mole_positions = occ[NUM_HOLES-1:0];
   assign busy           = (state_q == SPAWN);

   // Decode registered slots into a hole occupancy map.
   always_comb begin
      occ = '0;
      for (int i = 0; i < NUM_MOLES; i++)
         if (slots_q[i].active) occ[slots_q[i].pos] = 1'b1;
   end

   // Whack/aging per slot, then one SPAWN step for slot k.
   always_comb begin
      slots_d = slots_q;
      state_d = state_q;
      k_d     = k_q;
      tries_d = tries_q;
      hit_v   = '0;
      miss_v  = '0;
      wrong   = 1'b0;
      adv     = 1'b0;
      if (enable) begin
         wrong = |(whack & ~mole_positions);
         for (int i = 0; i < NUM_MOLES; i++) begin
            if (slots_q[i].active) begin
               if (whack_ext[slots_q[i].pos]) begin
                  hit_v[i]          = 1'b1;
                  slots_d[i].active = 1'b0;
               end else if (age_tick) begin
                  if (slots_q[i].life == LIFE_MAX_W'(1)) begin
                     miss_v[i]         = 1'b1;
                     slots_d[i].active = 1'b0;
                  end else begin
                     slots_d[i].life = slots_q[i].life - 1'b1;
                  end
               end
            end
         end
         unique case (state_q)
            IDLE: begin
               if (spawn_tick) begin
                  state_d = SPAWN;
                  k_d     = '0;
                  tries_d = '0;
               end
            end
            SPAWN: begin
               if (slots_q[k_q].active) begin
                  adv = 1'b1;
               end else if (cand_ok) begin
                  slots_d[k_q].active = 1'b1;
                  slots_d[k_q].pos    = cand;
                  slots_d[k_q].life   = life_ld;
                  adv = 1'b1;
               end else if (tries_q == TW'(MAX_TRIES - 1)) begin
                  adv = 1'b1;
               end else begin
                  tries_d = tries_q + 1'b1;
               end
               if (adv) begin
                  tries_d = '0;
                  if (k_q == KW'(NUM_MOLES - 1))
                     state_d = IDLE;
                  else
                     k_d = k_q + 1'b1;
               end
            end
         endcase
      end else begin
         state_d = IDLE;
      end
   end

   // Slot, FSM and spawn-index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_MOLES; i++) slots_q[i] <= '0;
         state_q <= IDLE;
         k_q     <= '0;
         tries_q <= '0;
      end else begin
         slots_q <= slots_d;
         state_q <= state_d;
         k_q     <= k_d;
         tries_q <= tries_d;
      end
   end

   // Registered event pulses and saturating score totals.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_pulse   <= 1'b0;
         miss_pulse  <= 1'b0;
         wrong_pulse <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
      end else begin
         hit_pulse   <= |hit_v;
         miss_pulse  <= |miss_v;
         wrong_pulse <= wrong;
         if (clear_scores) begin
            hit_count  <= '0;
            miss_count <= '0;
         end else begin
            hit_count  <= sat_add(hit_count, $countones(hit_v));
            miss_count <= sat_add(miss_count, $countones(miss_v));
         end
      end
   end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a cycle model.
// Expected outputs are queued per cycle and popped after the edge.
module tb_mole_scheduler;

   localparam int NM = 3;
   localparam int NH = 18;
   localparam int LW = 4;
   localparam int MT = 8;
   localparam int CW = 2;
   localparam int CMX = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          spawn_tick = 1'b0;
   logic          age_tick = 1'b0;
   logic [LW-1:0] lifetime = '0;
   logic [NH-1:0] whack = '0;
   logic          clear_scores = 1'b0;
   logic [NH-1:0] mole_positions;
   logic          busy, hit_pulse, miss_pulse, wrong_pulse;
   logic [CW-1:0] hit_count, miss_count;

   int checks = 0;
   int errors = 0;

   mole_scheduler #(
      .NUM_MOLES (NM),
      .NUM_HOLES (NH),
      .LIFE_W    (LW),
      .MAX_TRIES (MT),
      .SEED      (16'hACE1),
      .CNT_W     (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .spawn_tick     (spawn_tick),
      .age_tick       (age_tick),
      .lifetime       (lifetime),
      .whack          (whack),
      .clear_scores   (clear_scores),
      .mole_positions (mole_positions),
      .busy           (busy),
      .hit_pulse      (hit_pulse),
      .miss_pulse     (miss_pulse),
      .wrong_pulse    (wrong_pulse),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NH-1:0] pos;
      logic          busy;
      logic          hit;
      logic          miss;
      logic          wrong;
      logic [CW-1:0] hc;
      logic [CW-1:0] mc;
   } exp_t;

   exp_t sb[$];

   bit          m_act  [NM];
   int          m_pos  [NM];
   int          m_life [NM];
   bit          m_spawn;
   int          m_k, m_tries;
   logic [15:0] m_lfsr;
   int          m_hc, m_mc;
   bit          m_hp, m_mp, m_wp;

   function automatic void m_reset();
      for (int i = 0; i < NM; i++) begin
         m_act[i]  = 1'b0;
         m_pos[i]  = 0;
         m_life[i] = 0;
      end
      m_spawn = 1'b0;
      m_k     = 0;
      m_tries = 0;
      m_lfsr  = 16'hACE1;
      m_hc    = 0;
      m_mc    = 0;
      m_hp    = 1'b0;
      m_mp    = 1'b0;
      m_wp    = 1'b0;
   endfunction

   function automatic logic [NH-1:0] m_occ();
      logic [NH-1:0] o;
      o = '0;
      for (int i = 0; i < NM; i++)
         if (m_act[i]) o[m_pos[i]] = 1'b1;
      return o;
   endfunction

   function automatic int sat(input int v);
      return (v > CMX) ? CMX : v;
   endfunction

   // One clock of the reference behaviour, using current inputs.
   function automatic void m_step();
      bit            nact  [NM];
      int            npos  [NM];
      int            nlife [NM];
      bit            hitf  [NM];
      int            hits, misses, c;
      bit            wr, f, adv;
      logic [NH-1:0] occ;
      nact   = m_act;
      npos   = m_pos;
      nlife  = m_life;
      hits   = 0;
      misses = 0;
      wr     = 1'b0;
      occ    = m_occ();
      for (int i = 0; i < NM; i++) hitf[i] = 1'b0;
      if (enable) begin
         for (int p = 0; p < NH; p++) begin
            if (whack[p]) begin
               f = 1'b0;
               for (int i = 0; i < NM; i++)
                  if (m_act[i] && m_pos[i] == p) begin
                     nact[i] = 1'b0;
                     hitf[i] = 1'b1;
                     hits++;
                     f = 1'b1;
                  end
               if (!f) wr = 1'b1;
            end
         end
         if (age_tick)
            for (int i = 0; i < NM; i++)
               if (m_act[i] && !hitf[i]) begin
                  if (m_life[i] == 1) begin
                     nact[i] = 1'b0;
                     misses++;
                  end else begin
                     nlife[i] = m_life[i] - 1;
                  end
               end
         if (m_spawn) begin
            adv = 1'b0;
            c   = int'(m_lfsr & 16'h003F);
            if (m_act[m_k]) begin
               adv = 1'b1;
            end else if (c < NH && !occ[c]) begin
               nact[m_k]  = 1'b1;
               npos[m_k]  = c;
               nlife[m_k] = (lifetime == 0) ? 1 : int'(lifetime);
               adv = 1'b1;
            end else begin
               m_tries++;
               if (m_tries == MT) adv = 1'b1;
            end
            if (adv) begin
               m_tries = 0;
               if (m_k == NM - 1) m_spawn = 1'b0;
               else m_k++;
            end
         end else if (spawn_tick) begin
            m_spawn = 1'b1;
            m_k     = 0;
            m_tries = 0;
         end
         m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400)
                            : (m_lfsr >> 1);
      end else begin
         m_spawn = 1'b0;
      end
      if (clear_scores) begin
         m_hc = 0;
         m_mc = 0;
      end else begin
         m_hc = sat(m_hc + hits);
         m_mc = sat(m_mc + misses);
      end
      m_hp   = (hits > 0);
      m_mp   = (misses > 0);
      m_wp   = wr;
      m_act  = nact;
      m_pos  = npos;
      m_life = nlife;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      exp_t e, o;
      m_step();
      e.pos   = m_occ();
      e.busy  = m_spawn;
      e.hit   = m_hp;
      e.miss  = m_mp;
      e.wrong = m_wp;
      e.hc    = CW'(m_hc);
      e.mc    = CW'(m_mc);
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk("positions", 32'(mole_positions), 32'(o.pos));
      chk("busy", 32'(busy), 32'(o.busy));
      chk("hit_pulse", 32'(hit_pulse), 32'(o.hit));
      chk("miss_pulse", 32'(miss_pulse), 32'(o.miss));
      chk("wrong_pulse", 32'(wrong_pulse), 32'(o.wrong));
      chk("hit_count", 32'(hit_count), 32'(o.hc));
      chk("miss_count", 32'(miss_count), 32'(o.mc));
   endtask

   task automatic rst_chk(input string tg);
      chk({tg, "_pos"}, 32'(mole_positions), 32'd0);
      chk({tg, "_busy"}, 32'(busy), 32'd0);
      chk({tg, "_hitp"}, 32'(hit_pulse), 32'd0);
      chk({tg, "_missp"}, 32'(miss_pulse), 32'd0);
      chk({tg, "_wrongp"}, 32'(wrong_pulse), 32'd0);
      chk({tg, "_hc"}, 32'(hit_count), 32'd0);
      chk({tg, "_mc"}, 32'(miss_count), 32'd0);
   endtask

   task automatic do_spawn();
      int n;
      spawn_tick = 1'b1;
      tick();
      spawn_tick = 1'b0;
      n = 0;
      while (m_spawn && n < 40) begin
         tick();
         n++;
      end
      chk("spawn_bounded", 32'(n <= NM * MT), 32'd1);
      chk("spawn_done_busy", 32'(busy), 32'd0);
   endtask

   task automatic spawn_until_mole();
      for (int r = 0; r < 8; r++)
         if (m_occ() == '0) do_spawn();
      chk("have_mole", 32'(|mole_positions), 32'd1);
   endtask

   task automatic age_out();
      for (int r = 0; r < 16; r++) begin
         age_tick = 1'b1;
         tick();
         age_tick = 1'b0;
         tick();
      end
   endtask

   function automatic int first_pos();
      for (int i = 0; i < NM; i++)
         if (m_act[i]) return m_pos[i];
      return 0;
   endfunction

   function automatic int free_hole();
      logic [NH-1:0] o;
      o = m_occ();
      for (int p = 0; p < NH; p++)
         if (!o[p]) return p;
      return 0;
   endfunction

   initial begin
      int p, q, placed, hc0, mc0, others, raw_hits;
      logic [NH-1:0] w;

      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_chk("reset");
      rst_n  = 1'b1;
      enable = 1'b1;

      // Reset in the middle of a spawn.
      lifetime   = 4'd3;
      spawn_tick = 1'b1;
      tick();
      spawn_tick = 1'b0;
      chk("busy_in_spawn", 32'(busy), 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      rst_chk("mid_spawn_reset");
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill from a restarted LFSR.
      spawn_tick = 1'b1;
      tick();
      spawn_tick = 1'b0;
      chk("fill_busy_high", 32'(busy), 32'd1);
      for (int n = 0; n < 30 && m_spawn; n++) tick();
      chk("fill_busy_low", 32'(busy), 32'd0);
      placed = $countones(m_occ());
      chk("fill_count", 32'($countones(mole_positions)),
          32'(placed));

      // Expiry after three age ticks.
      for (int a = 0; a < 3; a++) begin
         if (a == 2)
            chk("pre_expiry_pos", 32'(mole_positions),
                32'(m_occ()));
         age_tick = 1'b1;
         tick();
         age_tick = 1'b0;
         if (a == 2) begin
            chk("expired_pos", 32'(mole_positions), 32'd0);
            chk("expired_missp", 32'(miss_pulse),
                32'(placed > 0));
            chk("expired_mc", 32'(miss_count), 32'(placed));
         end
         tick();
      end
      chk("miss_pulse_once", 32'(miss_pulse), 32'd0);

      // Hit plus wrong whack in one cycle.
      lifetime = 4'd3;
      spawn_until_mole();
      p = first_pos();
      q = free_hole();
      hc0 = m_hc;
      w = '0;
      w[p] = 1'b1;
      w[q] = 1'b1;
      whack = w;
      tick();
      whack = '0;
      chk("hw_cleared", 32'(mole_positions[p]), 32'd0);
      chk("hw_hitp", 32'(hit_pulse), 32'd1);
      chk("hw_wrongp", 32'(wrong_pulse), 32'd1);
      chk("hw_hc", 32'(hit_count), 32'(sat(hc0 + 1)));
      raw_hits = 1;

      // Hit racing with expiry on the same slot.
      age_out();
      lifetime = 4'd1;
      spawn_until_mole();
      p = first_pos();
      hc0 = m_hc;
      mc0 = m_mc;
      others = $countones(m_occ()) - 1;
      w = '0;
      w[p] = 1'b1;
      whack    = w;
      age_tick = 1'b1;
      tick();
      whack    = '0;
      age_tick = 1'b0;
      chk("race_hc", 32'(hit_count), 32'(sat(hc0 + 1)));
      chk("race_mc", 32'(miss_count), 32'(sat(mc0 + others)));
      chk("race_empty", 32'(mole_positions), 32'd0);
      raw_hits++;

      // Saturation of the hit counter.
      lifetime = 4'd5;
      for (int r = 0; r < 12 && raw_hits < 5; r++) begin
         spawn_until_mole();
         w = m_occ();
         raw_hits += $countones(w);
         whack = w;
         tick();
         whack = '0;
      end
      chk("sat_reached", 32'(raw_hits >= 5), 32'd1);
      chk("sat_hc", 32'(hit_count), 32'd3);

      // Clear wins over a same-cycle hit.
      spawn_until_mole();
      p = first_pos();
      w = '0;
      w[p] = 1'b1;
      whack        = w;
      clear_scores = 1'b1;
      tick();
      whack        = '0;
      clear_scores = 1'b0;
      chk("clr_hc", 32'(hit_count), 32'd0);
      chk("clr_mc", 32'(miss_count), 32'd0);
      chk("clr_hitp", 32'(hit_pulse), 32'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
